alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared external combinational ALU.
// Accepts one operation at a time, captures the ALU result and returns it on the winner's response port.
module alu_arbiter #(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_c,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] res_q, res_d;
  logic        win_q, win_d;
  logic        last_q, last_d;

  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [1:0]  grant;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // last_q holds the index of the most recently granted port.
  always_comb begin
    grant = 2'b00;
    if (FIXED_PRI) begin
      if (req_valid[0]) begin
        grant = 2'b01;
      end else if (req_valid[1]) begin
        grant = 2'b10;
      end
    end else begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    win_d     = win_q;
    last_d    = last_q;
    req_ready = 2'b00;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          req_ready = grant;
          a_d       = grant[1] ? req1_a  : req0_a;
          b_d       = grant[1] ? req1_b  : req0_b;
          op_d      = grant[1] ? req1_op : req0_op;
          win_d     = grant[1];
          last_d    = grant[1];
          state_d   = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_c;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[win_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      win_q   <= win_d;
      last_q  <= last_d;
    end
  end

  // Ready is combinational from the request inputs, so mask it while reset is held.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign rsp_valid[gi] = (state_q == RESP) && (win_q == 1'(gi));
  end

  assign req0_ready = req_ready[0] & rst_n;
  assign req1_ready = req_ready[1] & rst_n;
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp_data   = res_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign busy       = (state_q != IDLE);

endmodule
